// File: rtl/psmac_seq_ctrl_if.sv
// Operand/slice/result bundle between the operand source, the digit slice and the MAC sequencer.
interface psmac_seq_ctrl_if #(
    parameter int MAXD = 4,
    parameter int ACCW = 24
);
    logic                   start;
    logic                   clr_acc;
    logic [1:0]             prec;
    logic [2*MAXD-1:0]      a_mag;
    logic                   a_sgn;
    logic [2*MAXD-1:0]      b_mag;
    logic                   b_sgn;
    logic                   ready;
    logic                   done;
    logic [1:0]             dig_md;
    logic [1:0]             dig_mr;
    logic                   dig_sx;
    logic                   dig_sy;
    logic [4:0]             prod_i;
    logic [ACCW-1:0]        acc_o;
    logic                   ovf;

    modport master (
        output start, clr_acc, prec, a_mag, a_sgn, b_mag, b_sgn, prod_i,
        input  ready, done, dig_md, dig_mr, dig_sx, dig_sy, acc_o, ovf
    );

    modport slave (
        input  start, clr_acc, prec, a_mag, a_sgn, b_mag, b_sgn, prod_i,
        output ready, done, dig_md, dig_mr, dig_sx, dig_sy, acc_o, ovf
    );
endinterface

// File: rtl/psmac_seq_ctrl.sv
// Digit-serial sequencer for the 2-bit sign-magnitude multiplier slice: walks all digit pairs
// of the latched operands and accumulates the shifted signed partial products.
module psmac_seq_ctrl #(
    parameter int MAXD = 4,
    parameter int ACCW = 24
) (
    input  logic             clk,
    input  logic             rst,
    psmac_seq_ctrl_if.slave  bus
);
    localparam int IW = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int PW = 5 + 4 * (MAXD - 1);
    localparam int WW = ((ACCW > PW) ? ACCW : PW) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2*MAXD-1:0]     r_a_mag;
    logic [2*MAXD-1:0]     r_b_mag;
    logic                  r_a_sgn;
    logic                  r_b_sgn;
    logic [IW-1:0]         r_i;
    logic [IW-1:0]         r_j;
    logic [IW-1:0]         r_last;
    logic [IW-1:0]         w_i_nxt;
    logic [IW-1:0]         w_j_nxt;
    logic                  w_latch;
    logic [ACCW-1:0]       r_acc;
    logic [ACCW-1:0]       w_acc_nxt;
    logic                  r_ovf;
    logic                  w_ovf_nxt;
    logic [IW+1:0]         w_shamt;
    logic signed [WW-1:0]  w_acc_wide;
    logic signed [WW-1:0]  w_part;
    logic signed [WW-1:0]  w_sum;
    logic                  w_sum_ovf;
    logic [1:0]            w_md;
    logic [1:0]            w_mr;

    function automatic logic [IW-1:0] last_index(input logic [1:0] prec);
        int n;
        n = 1;
        case (prec)
            2'b00:   n = 1;
            2'b01:   n = 2;
            default: n = 4;
        endcase
        if (n > MAXD) begin
            n = MAXD;
        end else begin
            n = n;
        end
        return IW'(n - 1);
    endfunction

    // Datapath: select current digit pair and form the shifted, sign-extended partial sum.
    always_comb begin
        w_md       = r_a_mag[{r_i, 1'b0} +: 2];
        w_mr       = r_b_mag[{r_j, 1'b0} +: 2];
        w_shamt    = {({1'b0, r_i} + {1'b0, r_j}), 1'b0};
        w_acc_wide = {{(WW-ACCW){r_acc[ACCW-1]}}, r_acc};
        w_part     = {{(WW-5){bus.prod_i[4]}}, bus.prod_i} <<< w_shamt;
        w_sum      = w_acc_wide + w_part;
        // Judged on the exact sum so a partial that itself exceeds ACCW also flags overflow.
        w_sum_ovf  = ~((&w_sum[WW-1:ACCW-1]) | ~(|w_sum[WW-1:ACCW-1]));
    end

    // Next-state, loop counters and accumulator update.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clr_acc) begin
                    w_acc_nxt = {ACCW{1'b0}};
                    w_ovf_nxt = 1'b0;
                end else begin
                    w_acc_nxt = r_acc;
                end
                if (bus.start) begin
                    w_latch     = 1'b1;
                    w_i_nxt     = {IW{1'b0}};
                    w_j_nxt     = {IW{1'b0}};
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_acc_nxt = w_sum[ACCW-1:0];
                w_ovf_nxt = r_ovf | w_sum_ovf;
                if (r_j == r_last) begin
                    w_j_nxt = {IW{1'b0}};
                    if (r_i == r_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_nxt = r_i + {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_j_nxt = r_j + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, operand latches and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_mag <= {(2*MAXD){1'b0}};
            r_b_mag <= {(2*MAXD){1'b0}};
            r_a_sgn <= 1'b0;
            r_b_sgn <= 1'b0;
            r_i     <= {IW{1'b0}};
            r_j     <= {IW{1'b0}};
            r_last  <= {IW{1'b0}};
            r_acc   <= {ACCW{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            if (w_latch) begin
                r_a_mag <= bus.a_mag;
                r_b_mag <= bus.b_mag;
                r_a_sgn <= bus.a_sgn;
                r_b_sgn <= bus.b_sgn;
                r_last  <= last_index(bus.prec);
            end
        end
    end

    // Slice drive is live only while stepping through digit pairs.
    always_comb begin
        bus.dig_md = 2'b00;
        bus.dig_mr = 2'b00;
        bus.dig_sx = 1'b0;
        bus.dig_sy = 1'b0;
        if (r_state == S_RUN) begin
            bus.dig_md = w_md;
            bus.dig_mr = w_mr;
            bus.dig_sx = r_a_sgn;
            bus.dig_sy = r_b_sgn;
        end else begin
            bus.dig_md = 2'b00;
        end
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.acc_o = r_acc;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_psmac_seq_ctrl.sv
// Directed bench for psmac_seq_ctrl with a behavioural slice and an expected-result scoreboard.
module tb_psmac_seq_ctrl;
    logic clk;
    logic rst;

    psmac_seq_ctrl_if #(.MAXD(4), .ACCW(24)) bus24 ();
    psmac_seq_ctrl_if #(.MAXD(4), .ACCW(16)) bus16 ();

    psmac_seq_ctrl #(.MAXD(4), .ACCW(24)) dut24 (.clk(clk), .rst(rst), .bus(bus24));
    psmac_seq_ctrl #(.MAXD(4), .ACCW(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int     n_assert = 0;
    int     n_fail   = 0;
    longint acc_model = 0;
    longint exp_acc_q[$];
    logic [5:0] dig_q[$];

    function automatic logic [4:0] slice(input logic [1:0] md, input logic [1:0] mr,
                                         input logic sx, input logic sy);
        logic [4:0] m;
        m = 5'(md) * 5'(mr);
        return (sx ^ sy) ? (5'd0 - m) : m;
    endfunction

    assign bus24.prod_i = slice(bus24.dig_md, bus24.dig_mr, bus24.dig_sx, bus24.dig_sy);
    assign bus16.prod_i = slice(bus16.dig_md, bus16.dig_mr, bus16.dig_sx, bus16.dig_sy);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] p, input logic [7:0] a, input logic as,
                         input logic [7:0] b, input logic bs, input logic clr,
                         input logic hold_start, input logic scramble);
        int n;
        int runs;
        logic seen;
        logic [7:0] msk;
        longint prod;
        logic [63:0] acc_before;
        n    = (p == 2'b00) ? 1 : ((p == 2'b01) ? 2 : 4);
        msk  = (n == 1) ? 8'h03 : ((n == 2) ? 8'h0f : 8'hff);
        prod = longint'(a & msk) * longint'(b & msk);
        if (as ^ bs) prod = -prod;
        acc_model = (clr ? 64'sd0 : acc_model) + prod;
        exp_acc_q.push_back(acc_model);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                dig_q.push_back({a[2*i +: 2], b[2*j +: 2], as, bs});
        bus24.prec    = p;
        bus24.a_mag   = a;
        bus24.a_sgn   = as;
        bus24.b_mag   = b;
        bus24.b_sgn   = bs;
        bus24.clr_acc = clr;
        bus24.start   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) bus24.start = 1'b0;
        bus24.clr_acc = 1'b1 & hold_start;
        runs = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus24.done) begin
                seen = 1'b1;
            end else begin
                if (dig_q.size() > 0)
                    chk({tag, "_dig"}, {bus24.dig_md, bus24.dig_mr, bus24.dig_sx, bus24.dig_sy},
                        dig_q.pop_front());
                else
                    chk({tag, "_extra_run"}, 1, 0);
                runs++;
                if (scramble) begin
                    bus24.a_mag = 8'($urandom);
                    bus24.a_sgn = ~bus24.a_sgn;
                end
            end
        end
        dig_q.delete();
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_runs"}, runs, n * n);
        chk({tag, "_ready_in_done"}, bus24.ready, 0);
        chk({tag, "_dig_in_done"}, {bus24.dig_md, bus24.dig_mr, bus24.dig_sx, bus24.dig_sy}, 0);
        if (exp_acc_q.size() > 0) chk({tag, "_acc"}, $signed(bus24.acc_o), exp_acc_q.pop_front());
        chk({tag, "_ovf"}, bus24.ovf, 0);
        acc_before = bus24.acc_o;
        @(posedge clk);
        #1;
        bus24.start   = 1'b0;
        bus24.clr_acc = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after"}, bus24.ready, 1);
        chk({tag, "_done_1cyc"}, bus24.done, 0);
        if (hold_start) chk({tag, "_acc_held"}, bus24.acc_o, acc_before);
    endtask

    initial begin
        int runs;
        int dcount;
        logic seen;
        bus24.start = 1'b0; bus24.clr_acc = 1'b0; bus24.prec = 2'b00;
        bus24.a_mag = 8'h00; bus24.a_sgn = 1'b0; bus24.b_mag = 8'h00; bus24.b_sgn = 1'b0;
        bus16.start = 1'b0; bus16.clr_acc = 1'b0; bus16.prec = 2'b00;
        bus16.a_mag = 8'h00; bus16.a_sgn = 1'b0; bus16.b_mag = 8'h00; bus16.b_sgn = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus24.ready, 1);
        chk("rst_done", bus24.done, 0);
        chk("rst_dig", {bus24.dig_md, bus24.dig_mr, bus24.dig_sx, bus24.dig_sy}, 0);
        chk("rst_acc", bus24.acc_o, 0);
        chk("rst_ovf", bus24.ovf, 0);

        do_op("t1_3x2",       2'b00, 8'd3,   1'b0, 8'd2,   1'b0, 1'b1, 1'b0, 1'b0);
        do_op("t2_11xm7",     2'b01, 8'd11,  1'b0, 8'd7,   1'b1, 1'b1, 1'b0, 1'b0);
        do_op("t3_255sq",     2'b10, 8'd255, 1'b0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("t3_mac",       2'b10, 8'd255, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("mac_m5x9",     2'b01, 8'd5,   1'b1, 8'd9,   1'b0, 1'b0, 1'b0, 1'b0);
        do_op("t5_hold",      2'b01, 8'd6,   1'b0, 8'd10,  1'b1, 1'b0, 1'b1, 1'b0);

        // Reset during the third RUN cycle.
        bus24.prec = 2'b10; bus24.a_mag = 8'd77; bus24.b_mag = 8'd33;
        bus24.a_sgn = 1'b0; bus24.b_sgn = 1'b1; bus24.start = 1'b1;
        @(posedge clk);
        #1;
        bus24.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_model = 0;
        @(negedge clk);
        chk("t5_rst_ready", bus24.ready, 1);
        chk("t5_rst_acc", bus24.acc_o, 0);
        chk("t5_rst_dig", {bus24.dig_md, bus24.dig_mr, bus24.dig_sx, bus24.dig_sy}, 0);
        chk("t5_rst_ovf", bus24.ovf, 0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus24.done) dcount++;
        end
        chk("t5_rst_no_done", dcount, 0);

        do_op("t6_prec11",    2'b11, 8'd200, 1'b1, 8'd99,  1'b0, 1'b1, 1'b0, 1'b1);
        do_op("t6_prec10",    2'b10, 8'd200, 1'b1, 8'd99,  1'b0, 1'b1, 1'b0, 1'b0);

        // Narrow accumulator build: 255 x 255 wraps and flags overflow.
        @(negedge clk);
        bus16.prec = 2'b10; bus16.a_mag = 8'd255; bus16.b_mag = 8'd255;
        bus16.a_sgn = 1'b0; bus16.b_sgn = 1'b0; bus16.clr_acc = 1'b1; bus16.start = 1'b1;
        @(posedge clk);
        #1;
        bus16.start = 1'b0; bus16.clr_acc = 1'b0;
        runs = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus16.done) seen = 1'b1;
            else runs++;
        end
        chk("t4_done_seen", seen, 1);
        chk("t4_runs", runs, 16);
        chk("t4_acc", $signed(bus16.acc_o), -511);
        chk("t4_ovf", bus16.ovf, 1);
        @(negedge clk);
        chk("t4_ovf_sticky", bus16.ovf, 1);
        bus16.clr_acc = 1'b1;
        @(posedge clk);
        #1;
        bus16.clr_acc = 1'b0;
        @(negedge clk);
        chk("t4_clr_acc", bus16.acc_o, 0);
        chk("t4_clr_ovf", bus16.ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
